// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM arbiter slice: address width, slot tags
// carried down the read pipeline, and the CPU access FSM states.
package vram_pkg;

    localparam int ADDR_W = 13;

    // Owner of a memory slot; travels with the slot until its read data lands.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VID  = 2'd1,
        TAG_CPU  = 2'd2
    } slot_tag_e;

    // CPU access state: waiting for a slot, or issued and awaiting data.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PEND   = 2'd1,
        S_FLIGHT = 2'd2
    } cpu_state_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of every arbiter-facing signal except clock and reset.
// slave  : the arbiter side (takes CPU/video/latch requests, drives the SRAM).
// master : the system side (CPU, renderer, SRAM device, mode consumers).
//
// Handshake: CPU_REQ is a one-cycle strobe qualified only while CPU_WAIT_N=1;
// CPU_ACK is a one-cycle completion pulse with CPU_RDATA valid in that cycle
// and held afterwards. VID_RD is level-sensitive: each cycle it is high at a
// rising edge launches one fetch whose data appears on VID_DD two edges later.
interface vram_arbiter_if;
    import vram_pkg::*;

    logic              CPU_REQ;
    logic              CPU_WR;
    logic [ADDR_W-1:0] CPU_ADDR;
    logic [7:0]        CPU_WDATA;
    logic [7:0]        CPU_RDATA;
    logic              CPU_ACK;
    logic              CPU_WAIT_N;

    logic              LATCH_WR;
    logic [7:0]        LATCH_DATA;

    logic              VID_RD;
    logic [ADDR_W-1:0] VID_ADDR;
    logic [7:0]        VID_DD;

    logic [ADDR_W-1:0] MEM_ADDR;
    logic              MEM_WE;
    logic [7:0]        MEM_WDATA;
    logic [7:0]        MEM_RDATA;

    logic              MODE_AG;
    logic              MODE_CSS;
    logic [2:0]        MODE_GM;

    logic              STALL_ERR;
    cpu_state_e        DBG_CPU_STATE;

    modport slave (
        input  CPU_REQ, CPU_WR, CPU_ADDR, CPU_WDATA,
        output CPU_RDATA, CPU_ACK, CPU_WAIT_N,
        input  LATCH_WR, LATCH_DATA,
        input  VID_RD, VID_ADDR,
        output VID_DD,
        output MEM_ADDR, MEM_WE, MEM_WDATA,
        input  MEM_RDATA,
        output MODE_AG, MODE_CSS, MODE_GM,
        output STALL_ERR, DBG_CPU_STATE
    );

    modport master (
        output CPU_REQ, CPU_WR, CPU_ADDR, CPU_WDATA,
        input  CPU_RDATA, CPU_ACK, CPU_WAIT_N,
        output LATCH_WR, LATCH_DATA,
        output VID_RD, VID_ADDR,
        input  VID_DD,
        input  MEM_ADDR, MEM_WE, MEM_WDATA,
        output MEM_RDATA,
        input  MODE_AG, MODE_CSS, MODE_GM,
        input  STALL_ERR, DBG_CPU_STATE
    );

endinterface

// File: rtl/vz_mode_latch.sv
// VZ200 I/O mode latch (port 6800h). Only bits 3 and 4 are meaningful;
// GM is strapped to a constant for this machine.
module vz_mode_latch #(
    parameter logic [2:0] GM_DEFAULT = 3'b010
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       latch_wr,
    input  logic [7:0] latch_data,
    output logic       mode_ag,
    output logic       mode_css,
    output logic [2:0] mode_gm
);

    // Remaining data bits belong to other functions of the I/O port.
    logic unused_bits;
    assign unused_bits = ^{latch_data[7:5], latch_data[2:0]};

    // Capture AG/CSS on each latch write; independent of arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_ag  <= 1'b0;
            mode_css <= 1'b0;
        end else if (latch_wr) begin
            mode_ag  <= latch_data[3];
            mode_css <= latch_data[4];
        end
    end

    assign mode_gm = GM_DEFAULT;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetches always win the slot, the CPU waits
// (CPU_WAIT_N low) until a free slot appears. A two-stage tag pipeline follows
// each slot so returning SRAM data is routed to whoever issued it, regardless
// of what VID_RD is doing by the time the data arrives.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int         STALL_MAX  = 16,
    parameter logic [2:0] GM_DEFAULT = 3'b010
) (
    input logic           CLK,
    input logic           RESET_N,
    vram_arbiter_if.slave bus
);

    localparam int               CNT_W   = $clog2(STALL_MAX + 2);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STALL_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(STALL_MAX);

    cpu_state_e        state_q;
    cpu_state_e        state_d;
    slot_tag_e         slot_d;
    slot_tag_e         tag0_q;
    slot_tag_e         tag1_q;
    logic              accept_req;

    logic              req_wr_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [7:0]        req_wdata_q;

    logic              cpu_wr_sel;
    logic [ADDR_W-1:0] cpu_addr_sel;
    logic [7:0]        cpu_wdata_sel;

    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [7:0]        mem_wdata_q;

    logic [7:0]        vid_dd_q;
    logic [7:0]        cpu_rdata_q;
    logic              cpu_ack_q;

    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;
    logic              stall_err_q;

    // CPU FSM register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, slot owner and CPU access source for this edge.
    always_comb begin
        state_d       = state_q;
        slot_d        = TAG_NONE;
        accept_req    = 1'b0;
        cpu_wr_sel    = req_wr_q;
        cpu_addr_sel  = req_addr_q;
        cpu_wdata_sel = req_wdata_q;
        stall_cnt_d   = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.CPU_REQ) begin
                    accept_req = 1'b1;
                    state_d    = bus.VID_RD ? S_PEND : S_FLIGHT;
                end
            end
            S_PEND: begin
                if (!bus.VID_RD) begin
                    state_d = S_FLIGHT;
                end
            end
            S_FLIGHT: begin
                // The CPU slot reaches the end of the tag pipe two edges
                // after issue; that edge delivers the ACK.
                if (tag1_q == TAG_CPU) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A request issued straight from IDLE uses the live bus values;
        // a pending one uses what was latched when it was accepted.
        if (state_q == S_IDLE) begin
            cpu_wr_sel    = bus.CPU_WR;
            cpu_addr_sel  = bus.CPU_ADDR;
            cpu_wdata_sel = bus.CPU_WDATA;
        end

        if (bus.VID_RD) begin
            slot_d = TAG_VID;
        end else if (accept_req || (state_q == S_PEND)) begin
            slot_d = TAG_CPU;
        end

        if (state_q == S_PEND) begin
            stall_cnt_d = (stall_cnt_q == CNT_SAT) ? stall_cnt_q
                                                   : stall_cnt_q + CNT_W'(1);
        end
    end

    // Hold the accepted CPU access until it is issued and completed.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            req_wr_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
        end else if (accept_req) begin
            req_wr_q    <= bus.CPU_WR;
            req_addr_q  <= bus.CPU_ADDR;
            req_wdata_q <= bus.CPU_WDATA;
        end
    end

    // Drive the SRAM port for the slot decided at this edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            case (slot_d)
                TAG_VID: begin
                    mem_addr_q <= bus.VID_ADDR;
                    mem_we_q   <= 1'b0;
                end
                TAG_CPU: begin
                    mem_addr_q  <= cpu_addr_sel;
                    mem_we_q    <= cpu_wr_sel;
                    mem_wdata_q <= cpu_wdata_sel;
                end
                default: begin
                    mem_we_q <= 1'b0;
                end
            endcase
        end
    end

    // Slot tag pipeline matching the SRAM's one-cycle read latency.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            tag0_q <= TAG_NONE;
            tag1_q <= TAG_NONE;
        end else begin
            tag0_q <= slot_d;
            tag1_q <= tag0_q;
        end
    end

    // Route returning read data by tag and generate the CPU completion pulse.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            vid_dd_q    <= '0;
            cpu_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
        end else begin
            cpu_ack_q <= (tag1_q == TAG_CPU);
            if (tag1_q == TAG_VID) begin
                vid_dd_q <= bus.MEM_RDATA;
            end
            if ((tag1_q == TAG_CPU) && !req_wr_q) begin
                cpu_rdata_q <= bus.MEM_RDATA;
            end
        end
    end

    // Starvation watch: count PEND cycles, flag once the limit is exceeded.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            stall_cnt_q <= '0;
            stall_err_q <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            if (stall_cnt_d > CNT_LIM) begin
                stall_err_q <= 1'b1;
            end
        end
    end

    vz_mode_latch #(
        .GM_DEFAULT (GM_DEFAULT)
    ) u_mode_latch (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .latch_wr   (bus.LATCH_WR),
        .latch_data (bus.LATCH_DATA),
        .mode_ag    (bus.MODE_AG),
        .mode_css   (bus.MODE_CSS),
        .mode_gm    (bus.MODE_GM)
    );

    assign bus.MEM_ADDR      = mem_addr_q;
    assign bus.MEM_WE        = mem_we_q;
    assign bus.MEM_WDATA     = mem_wdata_q;
    assign bus.VID_DD        = vid_dd_q;
    assign bus.CPU_RDATA     = cpu_rdata_q;
    assign bus.CPU_ACK       = cpu_ack_q;
    assign bus.CPU_WAIT_N    = (state_q == S_IDLE);
    assign bus.STALL_ERR     = stall_err_q;
    assign bus.DBG_CPU_STATE = state_q;

endmodule
